// File: rtl/flop_clr.sv
// Decode-to-execute pipeline register: loads every clock, synchronous clear inserts
// an all-zero NOP bubble, asynchronous active-low reset zeroes everything.
module flop_clr #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [WIDTH-1:0] rd1d,
    input  logic [WIDTH-1:0] rd2d,
    input  logic [WIDTH-1:0] extimmd,
    input  logic [3:0]       wa3d,
    input  logic [3:0]       ra1d,
    input  logic [3:0]       ra2d,
    input  logic             pcsrcd,
    input  logic             regwrited,
    input  logic             memtoregd,
    input  logic             memwrited,
    input  logic             branchd,
    input  logic             alusrcd,
    input  logic [1:0]       flagwrited,
    input  logic [1:0]       alucontrold,
    input  logic [3:0]       flagsd,
    input  logic [3:0]       condd,
    output logic [WIDTH-1:0] rd1e,
    output logic [WIDTH-1:0] rd2e,
    output logic [WIDTH-1:0] extimme,
    output logic [3:0]       wa3e,
    output logic [3:0]       ra1e,
    output logic [3:0]       ra2e,
    output logic             pcsrce,
    output logic             regwritee,
    output logic             memtorege,
    output logic             memwritee,
    output logic             branche,
    output logic             alusrce,
    output logic [1:0]       flagwritee,
    output logic [1:0]       alucontrole,
    output logic [3:0]       flagse,
    output logic [3:0]       conde
);

    // A zeroed stage is a NOP: every write enable and branch/pcsrc bit is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd1e        <= '0;
            rd2e        <= '0;
            extimme     <= '0;
            wa3e        <= '0;
            ra1e        <= '0;
            ra2e        <= '0;
            pcsrce      <= 1'b0;
            regwritee   <= 1'b0;
            memtorege   <= 1'b0;
            memwritee   <= 1'b0;
            branche     <= 1'b0;
            alusrce     <= 1'b0;
            flagwritee  <= '0;
            alucontrole <= '0;
            flagse      <= '0;
            conde       <= '0;
        end else if (clr) begin
            rd1e        <= '0;
            rd2e        <= '0;
            extimme     <= '0;
            wa3e        <= '0;
            ra1e        <= '0;
            ra2e        <= '0;
            pcsrce      <= 1'b0;
            regwritee   <= 1'b0;
            memtorege   <= 1'b0;
            memwritee   <= 1'b0;
            branche     <= 1'b0;
            alusrce     <= 1'b0;
            flagwritee  <= '0;
            alucontrole <= '0;
            flagse      <= '0;
            conde       <= '0;
        end else begin
            rd1e        <= rd1d;
            rd2e        <= rd2d;
            extimme     <= extimmd;
            wa3e        <= wa3d;
            ra1e        <= ra1d;
            ra2e        <= ra2d;
            pcsrce      <= pcsrcd;
            regwritee   <= regwrited;
            memtorege   <= memtoregd;
            memwritee   <= memwrited;
            branche     <= branchd;
            alusrce     <= alusrcd;
            flagwritee  <= flagwrited;
            alucontrole <= alucontrold;
            flagse      <= flagsd;
            conde       <= condd;
        end
    end

endmodule

// File: tb/tb_flop_clr.sv
// Bench for flop_clr: vector table, corner-case sequences, walking one and
// randomized traffic against a one-cycle-delay reference model.
module tb_flop_clr;

    localparam int W     = 32;
    localparam int TOTAL = 3 * W + 30;

    typedef struct {
        logic [TOTAL-1:0] din;
        logic             clr;
        logic [TOTAL-1:0] expected;
    } vec_t;

    logic             clk;
    logic             reset;
    logic             clr;
    logic [TOTAL-1:0] din;
    logic [TOTAL-1:0] dout;

    logic [W-1:0] rd1e, rd2e, extimme;
    logic [3:0]   wa3e, ra1e, ra2e, flagse, conde;
    logic         pcsrce, regwritee, memtorege, memwritee, branche, alusrce;
    logic [1:0]   flagwritee, alucontrole;

    int assertCount = 0;
    int failCount   = 0;

    flop_clr #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .clr         (clr),
        .rd1d        (din[125:94]),
        .rd2d        (din[93:62]),
        .extimmd     (din[61:30]),
        .wa3d        (din[29:26]),
        .ra1d        (din[25:22]),
        .ra2d        (din[21:18]),
        .pcsrcd      (din[17]),
        .regwrited   (din[16]),
        .memtoregd   (din[15]),
        .memwrited   (din[14]),
        .branchd     (din[13]),
        .alusrcd     (din[12]),
        .flagwrited  (din[11:10]),
        .alucontrold (din[9:8]),
        .flagsd      (din[7:4]),
        .condd       (din[3:0]),
        .rd1e        (rd1e),
        .rd2e        (rd2e),
        .extimme     (extimme),
        .wa3e        (wa3e),
        .ra1e        (ra1e),
        .ra2e        (ra2e),
        .pcsrce      (pcsrce),
        .regwritee   (regwritee),
        .memtorege   (memtorege),
        .memwritee   (memwritee),
        .branche     (branche),
        .alusrce     (alusrce),
        .flagwritee  (flagwritee),
        .alucontrole (alucontrole),
        .flagse      (flagse),
        .conde       (conde)
    );

    assign dout = {rd1e, rd2e, extimme, wa3e, ra1e, ra2e,
                   pcsrce, regwritee, memtorege, memwritee, branche, alusrce,
                   flagwritee, alucontrole, flagse, conde};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [TOTAL-1:0] d, input logic c);
        din = d;
        clr = c;
    endtask

    task automatic checkOutput(input string name, input logic [TOTAL-1:0] expected);
        assertCount++;
        if (dout !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, dout, expected);
        end
    endtask

    function automatic logic [TOTAL-1:0] randomVec();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[TOTAL-1:0];
    endfunction

    vec_t             vecTable[$];
    logic [TOTAL-1:0] passVec, vA, vB, vC, model, oneHot;

    initial begin
        passVec = {32'h00000001, 32'h00000002, 32'h000000FF, 4'hA, 4'h3, 4'hC,
                   6'b111111, 2'b11, 2'b10, 4'b1001, 4'hE};
        vecTable.push_back('{passVec, 1'b0, passVec});
        vecTable.push_back('{passVec, 1'b1, '0});
        vecTable.push_back('{passVec, 1'b0, passVec});
        vecTable.push_back('{passVec, 1'b1, '0});
        vecTable.push_back('{passVec, 1'b1, '0});
        for (int k = 0; k < 5; k++) begin
            vA = randomVec() | TOTAL'(k + 1);
            vecTable.push_back('{vA, 1'b0, vA});
        end

        // Reset held low with busy inputs
        reset = 1'b0;
        applyStimulus({32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 4'h5, 4'h6, 4'h7,
                       6'b101101, 2'b01, 2'b11, 4'b0110, 4'h9}, 1'b0);
        #1 checkOutput("reset_before_edge", '0);
        repeat (2) @(posedge clk);
        #1 checkOutput("reset_hold", '0);
        clr = 1'b1;
        @(posedge clk);
        #1 checkOutput("reset_and_clr", '0);

        @(negedge clk);
        reset = 1'b1;
        clr   = 1'b0;
        @(posedge clk);
        #1 checkOutput("first_load_after_release", din);

        foreach (vecTable[i]) begin
            @(negedge clk);
            applyStimulus(vecTable[i].din, vecTable[i].clr);
            @(posedge clk);
            #1 checkOutput($sformatf("table_%0d", i), vecTable[i].expected);
        end

        // clr pulse that never spans an edge
        vA = randomVec();
        vB = randomVec();
        vC = randomVec();
        @(negedge clk);
        applyStimulus(vA, 1'b0);
        @(posedge clk);
        #1 checkOutput("glitch_setup", vA);
        #1 clr = 1'b1;
        #1 clr = 1'b0;
        checkOutput("glitch_hold", vA);
        @(negedge clk);
        applyStimulus(vB, 1'b0);
        @(posedge clk);
        #1 checkOutput("glitch_no_effect", vB);

        // Asynchronous reset mid-cycle
        #1 reset = 1'b0;
        #1 checkOutput("async_reset_mid", '0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(vC, 1'b0);
        #1 checkOutput("async_reset_held_zero", '0);
        @(posedge clk);
        #1 checkOutput("async_reset_reload", vC);

        for (int b = 0; b < TOTAL; b++) begin
            oneHot = '0;
            oneHot[b] = 1'b1;
            @(negedge clk);
            applyStimulus(oneHot, 1'b0);
            @(posedge clk);
            #1 checkOutput($sformatf("walk_%0d", b), oneHot);
        end

        // Randomized traffic with occasional clears and mid-cycle resets
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            applyStimulus(randomVec(), ($urandom_range(0, 3) == 0));
            model = clr ? '0 : din;
            if ($urandom_range(0, 15) == 0) begin
                #1 reset = 1'b0;
                #1 checkOutput($sformatf("rand_reset_%0d", n), '0);
                #1 reset = 1'b1;
            end
            @(posedge clk);
            #1 checkOutput($sformatf("rand_%0d", n), model);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
